// File: rtl/float_pkg.sv
// Shared constants and types for the float/int conversion blocks
// (float_to_int, int_to_float).
//   - IEEE-754 single-precision field widths and bit positions
//   - 8-bit integer range
//   - converter FSM state encoding and result flag bundle
package float_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int INT_W    = 8;
  localparam int CNT_W    = 5;

  localparam logic [INT_W-1:0] INT_MAX = 8'd255;

  // Field slices of {sign, exp[7:0], frac[22:0]}
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // At most one flag is set per result
  typedef struct packed {
    logic overflow;
    logic negative;
    logic invalid;
    logic inexact;
  } flags_t;

  // Number of positions to shift this cycle: min(remaining, step)
  function automatic logic [CNT_W-1:0] shift_amount(input logic [CNT_W-1:0] remaining,
                                                    input logic [CNT_W-1:0] step);
    logic [CNT_W-1:0] amount;
    if (remaining < step) begin
      amount = remaining;
    end else begin
      amount = step;
    end
    return amount;
  endfunction

endpackage

// File: rtl/float_to_int_if.sv
// Handshake bundle of float_to_int.
//   input side : in_valid, in_ready, float_input[31:0]
//   output side: out_valid, out_ready, int_output[7:0], flag_* (4 flags)
// master = producer/consumer environment, slave = converter.
interface float_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_input;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  int_output;
  logic        flag_overflow;
  logic        flag_negative;
  logic        flag_invalid;
  logic        flag_inexact;

  modport master (
    output in_valid, float_input, out_ready,
    input  in_ready, out_valid, int_output,
           flag_overflow, flag_negative, flag_invalid, flag_inexact
  );

  modport slave (
    input  in_valid, float_input, out_ready,
    output in_ready, out_valid, int_output,
           flag_overflow, flag_negative, flag_invalid, flag_inexact
  );
endinterface

// File: rtl/float_to_int_classify.sv
// Combinational decode of a single-precision value.
//   float_input : {sign, exp, frac}
//   is_nan/is_inf/is_zero : IEEE special classes
//   is_neg   : sign bit
//   is_small : nonzero with magnitude < 1.0 (includes denormals)
//   is_big   : magnitude >= 256 (exp >= 135, includes Inf/NaN exponents)
//   shift_cnt: 23 - (exp - 127), meaningful only for exp in 127..134
module float_classify
  import float_pkg::*;
(
  input  logic [31:0]      float_input,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero,
  output logic             is_neg,
  output logic             is_small,
  output logic             is_big,
  output logic [CNT_W-1:0] shift_cnt
);

  logic [EXP_W-1:0]  exp_s;
  logic [FRAC_W-1:0] frac_s;

  assign exp_s  = float_input[EXP_MSB:EXP_LSB];
  assign frac_s = float_input[FRAC_MSB:FRAC_LSB];

  // Class decode and initial right-shift distance
  always_comb begin
    is_nan    = (exp_s == 8'hFF) && (frac_s != 23'd0);
    is_inf    = (exp_s == 8'hFF) && (frac_s == 23'd0);
    is_zero   = (exp_s == 8'h00) && (frac_s == 23'd0);
    is_neg    = float_input[SIGN_BIT];
    is_small  = (exp_s < 8'd127) && !is_zero;
    is_big    = (exp_s >= 8'd135);
    // 150 = bias + fraction width; only the low 5 bits matter in range
    shift_cnt = CNT_W'(8'd150 - exp_s);
  end

endmodule

// File: rtl/float_to_int.sv
// Single-precision float to 8-bit unsigned integer, truncating.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : float_to_int_if.slave (valid/ready in, valid/ready out,
//                result and overflow/negative/invalid/inexact flags)
// Special values finish in one cycle; in-range values walk the 24-bit
// mantissa right by up to SHIFT_STEP positions per cycle.
module float_to_int
  import float_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  float_to_int_if.slave bus
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

  state_t            state_r, state_s;
  logic [MANT_W-1:0] mant_r, mant_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              sticky_r, sticky_s;
  logic [INT_W-1:0]  res_r, res_s;
  flags_t            flags_r, flags_s;
  logic              out_valid_r, out_valid_s;
  logic              in_ready_r;

  logic              is_nan_s, is_inf_s, is_zero_s, is_neg_s, is_small_s, is_big_s;
  logic [CNT_W-1:0]  shift_cnt_s;
  logic [CNT_W-1:0]  step_s;
  logic [MANT_W-1:0] shifted_s;
  logic              lost_s;
  logic [CNT_W-1:0]  cnt_dec_s;

  float_classify u_classify (
    .float_input (bus.float_input),
    .is_nan      (is_nan_s),
    .is_inf      (is_inf_s),
    .is_zero     (is_zero_s),
    .is_neg      (is_neg_s),
    .is_small    (is_small_s),
    .is_big      (is_big_s),
    .shift_cnt   (shift_cnt_s)
  );

  // One shifter step: shifted mantissa, OR of dropped bits, remaining count
  always_comb begin
    step_s    = shift_amount(cnt_r, STEP_C);
    shifted_s = mant_r >> step_s;
    lost_s    = |(mant_r & ~({MANT_W{1'b1}} << step_s));
    cnt_dec_s = cnt_r - step_s;
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_s     = state_r;
    mant_s      = mant_r;
    cnt_s       = cnt_r;
    sticky_s    = sticky_r;
    res_s       = res_r;
    flags_s     = flags_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          flags_s     = '0;
          res_s       = 8'd0;
          out_valid_s = 1'b1;
          state_s     = DONE;
          if (is_nan_s) begin
            flags_s.invalid = 1'b1;
          end else if (!is_neg_s && (is_inf_s || is_big_s)) begin
            res_s            = INT_MAX;
            flags_s.overflow = 1'b1;
          end else if (is_neg_s && !is_zero_s) begin
            flags_s.negative = 1'b1;
          end else if (is_zero_s) begin
            flags_s = '0;
          end else if (is_small_s) begin
            flags_s.inexact = 1'b1;
          end else begin
            // 1.0 <= value < 256: shift hidden-bit mantissa down to integer
            mant_s      = {1'b1, bus.float_input[FRAC_MSB:FRAC_LSB]};
            cnt_s       = shift_cnt_s;
            sticky_s    = 1'b0;
            out_valid_s = 1'b0;
            state_s     = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        mant_s   = shifted_s;
        sticky_s = sticky_r | lost_s;
        cnt_s    = cnt_dec_s;
        if (cnt_dec_s == 5'd0) begin
          res_s           = shifted_s[INT_W-1:0];
          flags_s         = '0;
          flags_s.inexact = sticky_r | lost_s;
          out_valid_s     = 1'b1;
          state_s         = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_r      <= '0;
      cnt_r       <= '0;
      sticky_r    <= 1'b0;
      res_r       <= '0;
      flags_r     <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      mant_r      <= mant_s;
      cnt_r       <= cnt_s;
      sticky_r    <= sticky_s;
      res_r       <= res_s;
      flags_r     <= flags_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= (state_s == IDLE);
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.int_output    = res_r;
  assign bus.flag_overflow = flags_r.overflow;
  assign bus.flag_negative = flags_r.negative;
  assign bus.flag_invalid  = flags_r.invalid;
  assign bus.flag_inexact  = flags_r.inexact;

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: three instances (SHIFT_STEP 1, 4, 23),
// directed vectors on the step-1 instance, int-to-float round trip on all.
module tb_float_to_int;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float_to_int_if b0 ();
  float_to_int_if b1 ();
  float_to_int_if b2 ();

  float_to_int #(.SHIFT_STEP(1))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  float_to_int #(.SHIFT_STEP(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  float_to_int #(.SHIFT_STEP(23)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  logic        iv [3];
  logic [31:0] fi [3];
  logic        ordy [3];
  logic        ir [3];
  logic        ov [3];
  logic [7:0]  oi [3];
  logic [3:0]  ofl [3];   // {overflow, negative, invalid, inexact}

  assign b0.in_valid = iv[0]; assign b0.float_input = fi[0]; assign b0.out_ready = ordy[0];
  assign b1.in_valid = iv[1]; assign b1.float_input = fi[1]; assign b1.out_ready = ordy[1];
  assign b2.in_valid = iv[2]; assign b2.float_input = fi[2]; assign b2.out_ready = ordy[2];
  assign ir[0] = b0.in_ready; assign ov[0] = b0.out_valid; assign oi[0] = b0.int_output;
  assign ir[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign oi[1] = b1.int_output;
  assign ir[2] = b2.in_ready; assign ov[2] = b2.out_valid; assign oi[2] = b2.int_output;
  assign ofl[0] = {b0.flag_overflow, b0.flag_negative, b0.flag_invalid, b0.flag_inexact};
  assign ofl[1] = {b1.flag_overflow, b1.flag_negative, b1.flag_invalid, b1.flag_inexact};
  assign ofl[2] = {b2.flag_overflow, b2.flag_negative, b2.flag_invalid, b2.flag_inexact};

  localparam logic [3:0] F_NONE = 4'b0000, F_OVF = 4'b1000, F_NEG = 4'b0100,
                         F_INV = 4'b0010, F_INX = 4'b0001;

  typedef struct {
    int         idx;
    logic [7:0] val;
    logic [3:0] fl;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   nchecks = 0;
  int   nerrs = 0;
  int   cyc = 0;
  bit   lat_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerrs++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency at first out_valid, value/flags on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k]) begin
          if (sb.size() == 0 || sb[0].idx != k) begin
            nchecks++;
            nerrs++;
            $display("FAIL unexpected_output inst=%0d actual=%0d required=none", k, oi[k]);
          end else begin
            if (!lat_done) begin
              chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
              lat_done = 1'b1;
            end
            if (ordy[k]) begin
              chk("int_output", int'(oi[k]), int'(sb[0].val));
              chk("flags", int'(ofl[k]), int'(sb[0].fl));
              void'(sb.pop_front());
              lat_done = 1'b0;
            end
          end
        end
      end
    end
  end

  // Offer one input right after a clock edge and hold until accepted
  task automatic send(input int idx, input logic [31:0] f, input logic [7:0] v,
                      input logic [3:0] fl, input int lat, input bit push);
    bit   done = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    iv[idx] = 1'b1;
    fi[idx] = f;
    for (int n = 0; n < 200 && !done; n++) begin
      if (ir[idx]) begin
        e.idx = idx; e.val = v; e.fl = fl; e.acc = cyc + 1; e.lat = lat;
        if (push) sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    iv[idx] = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  // Wait until the scoreboard empties; in_ready must stay low while busy
  task automatic drain(input int idx);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
      else if (!ov[idx]) chk("in_ready_busy", int'(ir[idx]), 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  function automatic int msb(input int i);
    int p = 0;
    for (int b = 0; b < 8; b++) if (i[b]) p = b;
    return p;
  endfunction

  // Reference int_to_float for 0..255
  function automatic logic [31:0] i2f(input int i);
    int p;
    logic [31:0] m;
    if (i == 0) return 32'h0000_0000;
    p = msb(i);
    m = 32'(i) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  initial begin
    int steps [3];
    int c;
    steps[0] = 1; steps[1] = 4; steps[2] = 23;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; fi[k] = 32'h0; ordy[k] = 1'b1;
    end
    #23;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", int'(ir[k]), 1);
      chk("reset_out_valid", int'(ov[k]), 0);
      chk("reset_int_output", int'(oi[k]), 0);
      chk("reset_flags", int'(ofl[k]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors on SHIFT_STEP=1
    send(0, 32'h3F800000, 8'd1,   F_NONE, 24, 1'b1); drain(0);   // 1.0
    send(0, 32'h40490FDB, 8'd3,   F_INX,  23, 1'b1); drain(0);   // 3.14159
    send(0, 32'h43000000, 8'd128, F_NONE, 17, 1'b1); drain(0);   // 128.0
    send(0, 32'h43800000, 8'd255, F_OVF,  1,  1'b1); drain(0);   // 256.0
    send(0, 32'h7FC00000, 8'd0,   F_INV,  1,  1'b1); drain(0);   // NaN
    send(0, 32'hC0000000, 8'd0,   F_NEG,  1,  1'b1); drain(0);   // -2.0
    send(0, 32'h80000000, 8'd0,   F_NONE, 1,  1'b1); drain(0);   // -0.0
    send(0, 32'h00000000, 8'd0,   F_NONE, 1,  1'b1); drain(0);   // +0.0
    send(0, 32'h7F800000, 8'd255, F_OVF,  1,  1'b1); drain(0);   // +Inf
    send(0, 32'hFF800000, 8'd0,   F_NEG,  1,  1'b1); drain(0);   // -Inf
    send(0, 32'h3F000000, 8'd0,   F_INX,  1,  1'b1); drain(0);   // 0.5
    send(0, 32'h00000001, 8'd0,   F_INX,  1,  1'b1); drain(0);   // denormal
    send(0, 32'h437F0000, 8'd255, F_NONE, 17, 1'b1); drain(0);   // 255.0
    send(0, 32'h437F8000, 8'd255, F_INX,  17, 1'b1); drain(0);   // 255.5
    send(0, 32'h3FC00000, 8'd1,   F_INX,  24, 1'b1); drain(0);   // 1.5

    // Backpressure: 100.0 held while a second input waits
    ordy[0] = 1'b0;
    send(0, 32'h42C80000, 8'd100, F_NONE, 18, 1'b1);
    for (int n = 0; n < 40 && !ov[0]; n++) begin @(posedge clk); #1; end
    chk("bp_out_valid_rise", int'(ov[0]), 1);
    iv[0] = 1'b1;
    fi[0] = 32'h40000000;                                      // 2.0
    for (int n = 0; n < 10; n++) begin
      chk("bp_hold_valid", int'(ov[0]), 1);
      chk("bp_hold_value", int'(oi[0]), 100);
      chk("bp_hold_flags", int'(ofl[0]), 0);
      chk("bp_in_ready", int'(ir[0]), 0);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    c = cyc;
    chk("bp_no_bypass", int'(ir[0]), 0);
    @(posedge clk); #1;                                        // handshake edge
    chk("bp_ready_after_hs", int'(ir[0]), 1);
    chk("bp_out_valid_drop", int'(ov[0]), 0);
    begin
      exp_t e;
      e.idx = 0; e.val = 8'd2; e.fl = F_NONE; e.acc = cyc + 1; e.lat = 23;
      chk("bp_accept_cycle", e.acc, c + 2);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    drain(0);

    // Asynchronous reset in the middle of SHIFT
    send(0, 32'h3F800000, 8'd1, F_NONE, 24, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(ov[0]), 0);
    chk("async_rst_in_ready", int'(ir[0]), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 32'h41200000, 8'd10, F_NONE, 21, 1'b1); drain(0);  // 10.0

    // Round trip through the reference int_to_float on every step size
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) begin
        int lat;
        lat = (i == 0) ? 1 : 1 + (23 - msb(i) + steps[k] - 1) / steps[k];
        send(k, i2f(i), 8'(i), F_NONE, lat, 1'b1);
        drain(k);
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Multi-cycle converter from IEEE-754 single precision to 8-bit unsigned integer.
- Inverse of the existing int_to_float block. A round trip of int_to_float followed by float_to_int is exact for 0..255.
- Rounds toward zero (truncates) using an iterative right shifter. Valid/ready handshake on both sides.
- Sits behind any float producer that must hand results to 8-bit integer datapaths.

Parameters:
- SHIFT_STEP, 1, maximum right-shift positions per SHIFT cycle (legal 1..23). Trades latency for area.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  float_input is valid.
- in_ready  output  1  block can accept an input; high only in IDLE.
- float_input  input  32  {sign, exp[7:0], frac[22:0]}.
- out_valid  output  1  int_output and flags are valid.
- out_ready  input  1  consumer accepts the result.
- int_output  output  8  converted value.
- flag_overflow  output  1  value >= 256 or +Inf; output saturated to 255.
- flag_negative  output  1  nonzero negative input, including -Inf; output clamped to 0.
- flag_invalid  output  1  NaN input; output 0.
- flag_inexact  output  1  nonzero fraction bits discarded by truncation; valid for finite in-range results only.

Behaviour:
- Reset (async assert, sync deassert by system): state=IDLE, in_ready=1, out_valid=0, int_output=0, all flags=0. Any conversion in flight is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE: in_ready=1. On in_valid & in_ready, register the input and classify it. Let e = exp-127.
  - NaN (exp=255, frac!=0): go to DONE, result 0, invalid=1.
  - +Inf, or sign=0 with e>=8: go to DONE, result 255, overflow=1.
  - sign=1 and not (exp=0 & frac=0): go to DONE, result 0, negative=1.
  - +/-0.0: go to DONE, result 0, no flags.
  - exp<127 (includes denormals), nonzero: go to DONE, result 0, inexact=1.
  - 0<=e<=7: load mant = {1,frac} (24 bits) and cnt = 23-e (16..23), clear sticky, go to SHIFT.
- SHIFT: each cycle, s = min(cnt, SHIFT_STEP).
  - mant <= mant>>s.
  - sticky |= OR of the bits shifted out.
  - cnt <= cnt-s.
  - When the new cnt = 0, go to DONE with result = mant[7:0] after the shift and inexact = sticky.
- DONE: out_valid=1. Outputs and flags are held stable until out_ready=1. The handshake cycle returns to IDLE.
- No input is accepted in SHIFT or DONE. Inputs arriving then stay pending until in_ready=1.
- No bypass: the earliest new accept is the cycle after out_valid & out_ready.
- Latency, counted from the accept edge to the first cycle out_valid=1:
  - Special cases: 1 cycle.
  - In-range values: 1 + ceil((23-e)/SHIFT_STEP) cycles. With SHIFT_STEP=1 this is 17 cycles for e=7 and 24 cycles for e=0.
- Flags are mutually exclusive per result.
- Outputs are registered; no combinational path from float_input to any output.
- Outputs are don't-care while out_valid=0, but are held at the last value; the bench checks them only when out_valid=1.

Decomposition:
- Shared package float_pkg holds:
  - EXP_BIAS=127, EXP_W=8, FRAC_W=23, MANT_W=24.
  - INT_W=8, INT_MAX=255.
  - State encoding: IDLE, SHIFT, DONE.
  - Field slice constants for sign, exp and frac.
  - Shared with int_to_float.
- One natural sub-module: float_classify. It is combinational and decodes float_input into is_nan, is_inf, is_zero, is_neg, is_small and is_big, plus the initial shift count. The FSM and shifter stay in float_to_int.

Test Plan:
- 0x3F800000 (1.0), SHIFT_STEP=1, out_ready=1 -> int_output=1, no flags, out_valid exactly 24 cycles after accept, in_ready low throughout.
- 0x40490FDB (3.14159) -> 3, inexact=1. 0x43000000 (128.0) -> 128, no flags, latency 17.
- 0x43800000 (256.0) -> 255, overflow=1, latency 1. 0x7FC00000 -> 0, invalid=1. 0xC0000000 (-2.0) -> 0, negative=1. 0x80000000 -> 0, no flags.
- Backpressure: convert 0x42C80000 (100.0) with out_ready=0 for 10 cycles -> out_valid and 100 held stable. A second in_valid during this time is not accepted until the cycle after the out_ready handshake.
- Reset: assert rst_n=0 mid-SHIFT -> out_valid=0 and in_ready=1 immediately (async). After release, 0x41200000 (10.0) -> 10 with correct latency.
- Round trip: for i=0..255, feed the int_to_float output into float_to_int -> int_output=i with all flags 0. Repeat with SHIFT_STEP=4 and SHIFT_STEP=23 (latency 2 for all in-range values).
